raster_scheduler: RTL and testbench
===================================

// Module: raster_scheduler
// PURPOSE
//  Queues decoded draw commands and sequences them onto the 8x8 framebuffer write port.
//  Pixel, fill-rect and clear are walked internally. Lines are delegated to the external line engine.
//  Arbitrates the framebuffer port between draw writes and display scanout. Scanout always wins.
// PARAMETERS
//  DEPTH  4  command FIFO entries (power of 2, >=2)
//  AW     2  FIFO pointer width, log2(DEPTH)
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  reset, asynchronous, active-low
//  cmd_valid  in   1  one-cycle command strobe from decoder
//  cmd_code   in   2  00 none, 01 pixel, 10 line, 11 fill_rect
//  cmd_clear  in   1  with code 01: clear whole grid
//  x1,y1      in   3  start coordinate
//  x2,y2      in   3  line end coordinate
//  width,h    in   3  rect extent (0 = 1 column/row)
//  cmd_full   out  1  FIFO full; commands offered now are dropped
//  overflow   out  1  sticky: a command was dropped
//  busy       out  1  FIFO non-empty or state != IDLE
//  scan_req   in   1  display wants the framebuffer port this cycle
//  scan_gnt   out  1  = scan_req (combinational)
//  fb_we      out  1  framebuffer write strobe
//  fb_x,fb_y  out  3  write address
//  fb_wdata   out  1  pixel value
//  line_start out  1  one-cycle start pulse to line engine
//  line_x1,line_y1,line_x2,line_y2  out  3  line coords, registered, stable from start until done
//  le_we      in   1  line engine pixel write
//  le_x,le_y  in   3  line engine pixel address
//  le_stall   out  1  line engine must hold its current write
//  line_done  in   1  one-cycle pulse: line finished
// BEHAVIOUR
//  Reset values: all outputs 0. FIFO empty, state IDLE, overflow cleared. Reset mid-operation aborts the command with no further writes.
//  Push: cmd_valid && !cmd_full writes {code,clear,coords} at the next edge.
//    cmd_valid && cmd_full drops the command and sets overflow.
//  Pop visibility: an entry pushed at edge N is poppable in cycle N. Push and pop in the same cycle are both legal.
//  FSM:
//    IDLE: if !empty, latch head, rd_ptr++, and go to:
//      code 00 -> IDLE (discard)
//      01 -> WALK (one pixel, or 64 if clear)
//      11 -> WALK
//      10 -> LSTART
//    WALK: fb_we = !scan_req. fb_x/fb_y from walk counters.
//      fb_wdata = 0 for clear, 1 otherwise.
//      Counters advance only on an issued write. Order: x fastest, then y.
//      Rect columns x1..min(x1+width,7), rows y1..min(y1+h,7). Clipped at 7, never wraps.
//      Clear covers (0,0)..(7,7).
//      After the last write -> IDLE. One bubble cycle before the next pop.
//    LSTART: line_start=1 for one cycle -> LWAIT.
//    LWAIT:
//      fb_we = le_we && !scan_req; fb_x/fb_y = le_x/le_y; fb_wdata = 1.
//      le_stall = scan_req.
//      line_done -> IDLE.
//      le_we outside LWAIT is ignored.
//  Latency: cmd_valid at cycle 0 into an idle, empty block gives the first fb_we in cycle 2.
//  Outside WALK/LWAIT: fb_we = 0 and le_stall = scan_req.
//  No draw write is lost or duplicated due to scan_req. The draw is merely delayed.
// STRUCTURE
//  raster_pkg:
//    CMD_NONE/PIXEL/LINE/RECT codes
//    COORD_W=3, GRID_MAX=7
//    FSM state encodings
//    FIFO entry struct/width
//  Sub-module raster_cmd_fifo:
//    DEPTH x entry
//    wr/rd pointers with extra wrap bit; full/empty registered
// TESTING
//  1 pixel (3,5), idle -> single fb_we in cycle 2, fb_x=3 fb_y=5 wdata=1. busy drops after.
//  2 rect x1=6 y1=6 w=3 h=1 -> exactly 4 writes: (6,6),(7,6),(6,7),(7,7). No wrap.
//  3 clear -> 64 consecutive writes, wdata=0, (0,0)..(7,7) x-fastest.
//  4 scan_req high 5 cycles mid-rect -> fb_we low, scan_gnt high. Resumes at same pixel. Total write count unchanged.
//  5 six back-to-back cmd_valid while busy, DEPTH=4:
//    cmd_full after 4th, later commands dropped, overflow=1.
//    Four queued commands execute in order.
//  6 line (0,0)-(7,7):
//    line_start one cycle, coords stable until line_done.
//    le writes forwarded; le_stall follows scan_req.
//    rst_n low mid-LWAIT -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/raster_scheduler_pkg.sv
// Shared types for the raster scheduler: command codes, FSM states and the
// queued command entry layout.
package raster_scheduler_pkg;

  localparam int COORD_W  = 3;
  localparam int GRID_MAX = 7;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_PIXEL = 2'b01,
    CMD_LINE  = 2'b10,
    CMD_RECT  = 2'b11
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WALK   = 2'b01,
    ST_LSTART = 2'b10,
    ST_LWAIT  = 2'b11
  } state_e;

  typedef struct packed {
    cmd_code_e code;
    logic      clear;
    coord_t    x1;
    coord_t    y1;
    coord_t    x2;
    coord_t    y2;
    coord_t    width;
    coord_t    h;
  } cmd_entry_t;

  // Last covered column/row of a rect; saturates at the grid edge instead of wrapping.
  function automatic coord_t clip_end(coord_t start, coord_t extent);
    logic [COORD_W:0] sum;
    sum = {1'b0, start} + {1'b0, extent};
    return sum[COORD_W] ? coord_t'(GRID_MAX) : sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/raster_scheduler_if.sv
// Command, framebuffer, scanout and line-engine signals of the raster scheduler.
// The scheduler takes the slave view; the surrounding system takes the master view.
interface raster_scheduler_if;
  import raster_scheduler_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_clear;
  coord_t     x1, y1, x2, y2, width, h;
  logic       cmd_full;
  logic       overflow;
  logic       busy;

  logic       scan_req;
  logic       scan_gnt;

  logic       fb_we;
  coord_t     fb_x, fb_y;
  logic       fb_wdata;

  logic       line_start;
  coord_t     line_x1, line_y1, line_x2, line_y2;
  logic       le_we;
  coord_t     le_x, le_y;
  logic       le_stall;
  logic       line_done;

  modport slave (
    input  cmd_valid, cmd_code, cmd_clear, x1, y1, x2, y2, width, h,
    input  scan_req, le_we, le_x, le_y, line_done,
    output cmd_full, overflow, busy, scan_gnt, fb_we, fb_x, fb_y, fb_wdata,
    output line_start, line_x1, line_y1, line_x2, line_y2, le_stall
  );

  modport master (
    output cmd_valid, cmd_code, cmd_clear, x1, y1, x2, y2, width, h,
    output scan_req, le_we, le_x, le_y, line_done,
    input  cmd_full, overflow, busy, scan_gnt, fb_we, fb_x, fb_y, fb_wdata,
    input  line_start, line_x1, line_y1, line_x2, line_y2, le_stall
  );

endinterface

// File: rtl/raster_scheduler_cmd_fifo.sv
// Command queue. Pointers carry an extra wrap bit; full/empty are registered
// so an entry written at an edge is visible as the head right after it.
module raster_scheduler_cmd_fifo
  import raster_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  cmd_entry_t wdata_i,
  input  logic       pop_i,
  output cmd_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  cmd_entry_t      mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            do_push, do_pop;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/raster_scheduler.sv
// Pops queued draw commands, walks pixel/rect/clear itself, hands lines to the
// external line engine, and yields the framebuffer port to scanout every cycle it asks.
module raster_scheduler
  import raster_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic               clk,
  input logic               rst_n,
  raster_scheduler_if.slave rs
);

  state_e     state_q, state_d;
  coord_t     xs_q, xs_d;
  coord_t     xe_q, xe_d;
  coord_t     ye_q, ye_d;
  coord_t     cx_q, cx_d;
  coord_t     cy_q, cy_d;
  logic       wdata_q, wdata_d;
  coord_t     lx1_q, lx1_d, ly1_q, ly1_d, lx2_q, lx2_d, ly2_q, ly2_d;
  logic       overflow_q;

  cmd_entry_t cmd_in, head;
  logic       fifo_full, fifo_empty, pop;
  logic       fb_we, fb_wdata, line_start;
  coord_t     fb_x, fb_y;

  assign cmd_in = '{code: cmd_code_e'(rs.cmd_code), clear: rs.cmd_clear,
                    x1: rs.x1, y1: rs.y1, x2: rs.x2, y2: rs.y2,
                    width: rs.width, h: rs.h};

  raster_scheduler_cmd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rs.cmd_valid),
    .wdata_i (cmd_in),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    wdata_d    = wdata_q;
    lx1_d      = lx1_q;
    ly1_d      = ly1_q;
    lx2_d      = lx2_q;
    ly2_d      = ly2_q;
    pop        = 1'b0;
    fb_we      = 1'b0;
    fb_x       = '0;
    fb_y       = '0;
    fb_wdata   = 1'b0;
    line_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head.code)
            CMD_PIXEL: begin
              state_d = ST_WALK;
              wdata_d = !head.clear;
              // A clear is a full-grid walk; a pixel is a 1x1 walk.
              if (head.clear) begin
                xs_d = '0;
                cx_d = '0;
                cy_d = '0;
                xe_d = coord_t'(GRID_MAX);
                ye_d = coord_t'(GRID_MAX);
              end else begin
                xs_d = head.x1;
                cx_d = head.x1;
                cy_d = head.y1;
                xe_d = head.x1;
                ye_d = head.y1;
              end
            end
            CMD_RECT: begin
              state_d = ST_WALK;
              wdata_d = 1'b1;
              xs_d    = head.x1;
              cx_d    = head.x1;
              cy_d    = head.y1;
              xe_d    = clip_end(head.x1, head.width);
              ye_d    = clip_end(head.y1, head.h);
            end
            CMD_LINE: begin
              state_d = ST_LSTART;
              lx1_d   = head.x1;
              ly1_d   = head.y1;
              lx2_d   = head.x2;
              ly2_d   = head.y2;
            end
            default: ;
          endcase
        end
      end
      ST_WALK: begin
        fb_we    = !rs.scan_req;
        fb_x     = cx_q;
        fb_y     = cy_q;
        fb_wdata = wdata_q;
        // Walk position only moves on a write that actually went out.
        if (!rs.scan_req) begin
          if (cx_q == xe_q) begin
            if (cy_q == ye_q) begin
              state_d = ST_IDLE;
            end else begin
              cx_d = xs_q;
              cy_d = cy_q + 3'd1;
            end
          end else begin
            cx_d = cx_q + 3'd1;
          end
        end
      end
      ST_LSTART: begin
        line_start = 1'b1;
        state_d    = ST_LWAIT;
      end
      ST_LWAIT: begin
        fb_we    = rs.le_we && !rs.scan_req;
        fb_x     = rs.le_x;
        fb_y     = rs.le_y;
        fb_wdata = 1'b1;
        if (rs.line_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      xs_q       <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wdata_q    <= 1'b0;
      lx1_q      <= '0;
      ly1_q      <= '0;
      lx2_q      <= '0;
      ly2_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      wdata_q <= wdata_d;
      lx1_q   <= lx1_d;
      ly1_q   <= ly1_d;
      lx2_q   <= lx2_d;
      ly2_q   <= ly2_d;
      if (rs.cmd_valid && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign rs.cmd_full   = fifo_full;
  assign rs.overflow   = overflow_q;
  assign rs.busy       = !fifo_empty || (state_q != ST_IDLE);
  assign rs.scan_gnt   = rs.scan_req;
  assign rs.le_stall   = rs.scan_req;
  assign rs.fb_we      = fb_we;
  assign rs.fb_x       = fb_x;
  assign rs.fb_y       = fb_y;
  assign rs.fb_wdata   = fb_wdata;
  assign rs.line_start = line_start;
  assign rs.line_x1    = lx1_q;
  assign rs.line_y1    = ly1_q;
  assign rs.line_x2    = lx2_q;
  assign rs.line_y2    = ly2_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: randomized draw commands checked against a
// write-list model built from the drawing rules, plus scanout and line-engine scenarios.
module tb_raster_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
    int d;
  } wr_t;

  wr_t cap[$];
  wr_t expq[$];

  raster_scheduler_if rs();

  raster_scheduler #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (rs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rs.fb_we)
      cap.push_back('{cyc, int'(rs.fb_x), int'(rs.fb_y), int'(rs.fb_wdata)});
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Reference: list of framebuffer writes a command must produce, in order.
  task automatic model_cmd(input int code, input int clr, input int x1, input int y1,
                           input int w, input int hh);
    int xe, ye;
    if (code == 1 && clr != 0) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) expq.push_back('{0, x, y, 0});
    end else if (code == 1) begin
      expq.push_back('{0, x1, y1, 1});
    end else if (code == 3) begin
      xe = (x1 + w > 7) ? 7 : x1 + w;
      ye = (y1 + hh > 7) ? 7 : y1 + hh;
      for (int y = y1; y <= ye; y++)
        for (int x = x1; x <= xe; x++) expq.push_back('{0, x, y, 1});
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++)
      if (cap[i].x != expq[i].x || cap[i].y != expq[i].y || cap[i].d != expq[i].d) return i;
    if (cap.size() != expq.size()) return n;
    return -1;
  endfunction

  function automatic logic [25:0] outvec();
    return {rs.fb_we, rs.busy, rs.cmd_full, rs.overflow, rs.line_start, rs.fb_x, rs.fb_y,
            rs.fb_wdata, rs.le_stall, rs.scan_gnt, rs.line_x1, rs.line_y1, rs.line_x2, rs.line_y2};
  endfunction

  task automatic set_cmd(input int code, input int clr, input int x1, input int y1,
                         input int x2, input int y2, input int w, input int hh);
    rs.cmd_valid = 1'b1;
    rs.cmd_code  = 2'(code);
    rs.cmd_clear = 1'(clr);
    rs.x1 = 3'(x1); rs.y1 = 3'(y1); rs.x2 = 3'(x2); rs.y2 = 3'(y2);
    rs.width = 3'(w); rs.h = 3'(hh);
  endtask

  task automatic wait_idle(input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!rs.busy) begin
        timeout = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rs.cmd_valid = 0; rs.cmd_code = 0; rs.cmd_clear = 0;
    rs.x1 = 0; rs.y1 = 0; rs.x2 = 0; rs.y2 = 0; rs.width = 0; rs.h = 0;
    rs.scan_req = 0; rs.le_we = 0; rs.le_x = 0; rs.le_y = 0; rs.line_done = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (outvec() !== 26'd0) begin
      bad++; $display("FAIL reset_outputs: got=%h want=0", outvec());
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (outvec() !== 26'd0) begin
      bad++; $display("FAIL post_reset_outputs: got=%h want=0", outvec());
    end
    $display("reset: outputs=%h", outvec());
  endtask

  task automatic test_pixel();
    int c0, fd, x, y;
    bit to;
    for (int k = 0; k < 5; k++) begin
      x = (k == 0) ? 3 : $urandom_range(0, 7);
      y = (k == 0) ? 5 : $urandom_range(0, 7);
      cap.delete(); expq.delete();
      @(posedge clk); #1;
      set_cmd(1, 0, x, y, 0, 0, 0, 0);
      c0 = cyc;
      model_cmd(1, 0, x, y, 0, 0);
      @(posedge clk); #1;
      rs.cmd_valid = 1'b0;
      wait_idle(50, to);
      total++;
      if (to || cyc != c0 + 3) begin
        bad++; $display("FAIL pixel_busy_drop: idle at cycle %0d want %0d (timeout=%0d)", cyc - c0, 3, to);
      end
      total++;
      if (cap.size() == 0 || cap[0].cyc != c0 + 2) begin
        bad++; $display("FAIL pixel_latency: first write at +%0d want +2", (cap.size() == 0) ? -1 : cap[0].cyc - c0);
      end
      fd = first_diff();
      total++;
      if (fd != -1) begin
        bad++; $display("FAIL pixel_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
      end
      $display("pixel (%0d,%0d): writes=%0d", x, y, cap.size());
    end
  endtask

  task automatic test_rect();
    int c0, fd, x, y, w, hh;
    bit to;
    for (int k = 0; k < 5; k++) begin
      x  = (k == 0) ? 6 : $urandom_range(0, 7);
      y  = (k == 0) ? 6 : $urandom_range(0, 7);
      w  = (k == 0) ? 3 : $urandom_range(0, 7);
      hh = (k == 0) ? 1 : $urandom_range(0, 7);
      cap.delete(); expq.delete();
      @(posedge clk); #1;
      set_cmd(3, 0, x, y, 0, 0, w, hh);
      c0 = cyc;
      model_cmd(3, 0, x, y, w, hh);
      @(posedge clk); #1;
      rs.cmd_valid = 1'b0;
      wait_idle(200, to);
      total++;
      if (to) begin
        bad++; $display("FAIL rect_timeout: busy=%0d want 0", rs.busy);
      end
      fd = first_diff();
      total++;
      if (fd != -1) begin
        bad++; $display("FAIL rect_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
      end
      total++;
      if (cap.size() == 0 || cap[0].cyc != c0 + 2 || cap[cap.size()-1].cyc != c0 + 1 + expq.size()) begin
        bad++; $display("FAIL rect_timing: got %0d writes want consecutive from +2 to +%0d", cap.size(), 1 + expq.size());
      end
      $display("rect (%0d,%0d) w=%0d h=%0d: writes=%0d", x, y, w, hh, cap.size());
    end
  endtask

  task automatic test_clear();
    int c0, fd;
    bit to;
    cap.delete(); expq.delete();
    @(posedge clk); #1;
    set_cmd(1, 1, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 0, 0);
    c0 = cyc;
    model_cmd(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rs.cmd_valid = 1'b0;
    wait_idle(200, to);
    fd = first_diff();
    total++;
    if (to || fd != -1) begin
      bad++; $display("FAIL clear_writes: diff idx %0d got %0d writes want 64", fd, cap.size());
    end
    total++;
    if (cap.size() == 0 || cap[0].cyc != c0 + 2 || cap[cap.size()-1].cyc != c0 + 65) begin
      bad++; $display("FAIL clear_timing: got %0d writes want 64 consecutive from +2", cap.size());
    end
    $display("clear: writes=%0d", cap.size());
  endtask

  task automatic test_scan();
    int c0, fd, viol, x, y, w, hh;
    bit to, sr;
    // Fixed 5-cycle scanout burst in the middle of a 16-pixel rect.
    cap.delete(); expq.delete();
    @(posedge clk); #1;
    set_cmd(3, 0, 0, 0, 0, 0, 7, 1);
    c0 = cyc;
    model_cmd(3, 0, 0, 0, 7, 1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      rs.cmd_valid = 1'b0;
      rs.scan_req = (i >= 5);
      @(negedge clk);
      if (rs.scan_req) begin
        total++;
        if (rs.fb_we !== 1'b0 || rs.scan_gnt !== 1'b1) begin
          bad++; $display("FAIL scan_block: fb_we=%0d scan_gnt=%0d want 0/1", rs.fb_we, rs.scan_gnt);
        end
      end
    end
    @(posedge clk); #1;
    rs.scan_req = 1'b0;
    wait_idle(100, to);
    fd = first_diff();
    total++;
    if (to || fd != -1) begin
      bad++; $display("FAIL scan_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
    end
    total++;
    if (cap.size() == 0 || cap[cap.size()-1].cyc != c0 + 22 || cap.size() < 4 || cap[3].cyc != c0 + 10) begin
      bad++; $display("FAIL scan_resume: got %0d writes, last at +%0d want 16 ending +22",
                      cap.size(), (cap.size() == 0) ? -1 : cap[cap.size()-1].cyc - c0);
    end
    $display("scan burst: writes=%0d", cap.size());

    // Random scanout pressure over random rects.
    for (int k = 0; k < 3; k++) begin
      x = $urandom_range(0, 7); y = $urandom_range(0, 7);
      w = $urandom_range(0, 7); hh = $urandom_range(0, 7);
      cap.delete(); expq.delete();
      viol = 0; to = 1'b1;
      @(posedge clk); #1;
      set_cmd(3, 0, x, y, 0, 0, w, hh);
      model_cmd(3, 0, x, y, w, hh);
      for (int i = 0; i < 600; i++) begin
        @(posedge clk); #1;
        rs.cmd_valid = 1'b0;
        sr = ($urandom_range(0, 2) == 0);
        rs.scan_req = sr;
        @(negedge clk);
        if ((rs.fb_we && sr) || rs.scan_gnt !== sr) viol++;
        if (!rs.busy) begin
          to = 1'b0;
          break;
        end
      end
      rs.scan_req = 1'b0;
      total++;
      if (viol != 0 || to) begin
        bad++; $display("FAIL scan_random_arb: violations=%0d timeout=%0d want 0/0", viol, to);
      end
      fd = first_diff();
      total++;
      if (fd != -1) begin
        bad++; $display("FAIL scan_random_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
      end
      $display("scan random rect (%0d,%0d) w=%0d h=%0d: writes=%0d", x, y, w, hh, cap.size());
    end
  endtask

  task automatic test_back_to_back();
    int fd, code, x, y, w, hh;
    bit to;
    cap.delete(); expq.delete();
    @(posedge clk); #1;
    set_cmd(1, 1, 0, 0, 0, 0, 0, 0);
    model_cmd(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rs.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      code = ($urandom_range(0, 1) == 0) ? 1 : 3;
      x = $urandom_range(0, 7); y = $urandom_range(0, 7);
      w = $urandom_range(0, 3); hh = $urandom_range(0, 3);
      set_cmd(code, 0, x, y, 0, 0, w, hh);
      if (i < 4) model_cmd(code, 0, x, y, w, hh);
      @(negedge clk);
      total++;
      if (rs.cmd_full !== (i >= 4)) begin
        bad++; $display("FAIL b2b_full[%0d]: got=%0d want=%0d", i, rs.cmd_full, (i >= 4));
      end
      if (i == 4) begin
        total++;
        if (rs.overflow !== 1'b0) begin
          bad++; $display("FAIL b2b_overflow_early: got=%0d want=0", rs.overflow);
        end
      end
    end
    @(posedge clk); #1;
    rs.cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (rs.overflow !== 1'b1) begin
      bad++; $display("FAIL b2b_overflow: got=%0d want=1", rs.overflow);
    end
    wait_idle(1500, to);
    fd = first_diff();
    total++;
    if (to || fd != -1) begin
      bad++; $display("FAIL b2b_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
    end
    $display("back_to_back: writes=%0d overflow=%0d", cap.size(), rs.overflow);
  endtask

  task automatic test_line();
    int c0, ls, n, fd, px, py, viol;
    bit to, sr;
    // Line-engine writes are ignored while no line is active.
    @(posedge clk); #1;
    rs.le_we = 1'b1; rs.le_x = 3'd2; rs.le_y = 3'd4;
    @(negedge clk);
    total++;
    if (rs.fb_we !== 1'b0) begin
      bad++; $display("FAIL le_ignored_idle: fb_we=%0d want 0", rs.fb_we);
    end

    cap.delete(); expq.delete();
    @(posedge clk); #1;
    rs.le_we = 1'b0;
    set_cmd(2, 0, 0, 0, 7, 7, 0, 0);
    c0 = cyc;
    @(posedge clk); #1;
    rs.cmd_valid = 1'b0;
    ls = -1;
    for (int i = 0; i < 10 && ls < 0; i++) begin
      @(negedge clk);
      if (rs.line_start) ls = cyc;
    end
    total++;
    if (ls != c0 + 2) begin
      bad++; $display("FAIL line_start_cycle: got +%0d want +2", (ls < 0) ? -1 : ls - c0);
    end
    total++;
    if ({rs.line_x1, rs.line_y1, rs.line_x2, rs.line_y2} !== 12'o0077) begin
      bad++; $display("FAIL line_coords: got %0d,%0d-%0d,%0d want 0,0-7,7",
                      rs.line_x1, rs.line_y1, rs.line_x2, rs.line_y2);
    end
    n = 0; viol = 0;
    px = $urandom_range(0, 7); py = $urandom_range(0, 7);
    for (int i = 0; i < 300 && n < 8; i++) begin
      @(posedge clk); #1;
      sr = ($urandom_range(0, 2) == 0);
      rs.scan_req = sr;
      rs.le_we = 1'b1; rs.le_x = 3'(px); rs.le_y = 3'(py);
      @(negedge clk);
      if (rs.line_start !== 1'b0 || rs.le_stall !== sr ||
          {rs.line_x1, rs.line_y1, rs.line_x2, rs.line_y2} !== 12'o0077) viol++;
      if (!sr) begin
        expq.push_back('{0, px, py, 1});
        n++;
        px = $urandom_range(0, 7); py = $urandom_range(0, 7);
      end
    end
    @(posedge clk); #1;
    rs.le_we = 1'b0; rs.scan_req = 1'b0; rs.line_done = 1'b1;
    @(posedge clk); #1;
    rs.line_done = 1'b0;
    wait_idle(20, to);
    total++;
    if (viol != 0 || to) begin
      bad++; $display("FAIL line_handshake: violations=%0d timeout=%0d want 0/0", viol, to);
    end
    fd = first_diff();
    total++;
    if (fd != -1) begin
      bad++; $display("FAIL line_writes: diff idx %0d got %0d writes want %0d", fd, cap.size(), expq.size());
    end
    $display("line (0,0)-(7,7): forwarded writes=%0d", cap.size());

    // Reset while a line is in flight and a pixel waits in the queue.
    @(posedge clk); #1;
    set_cmd(2, 0, 1, 2, 5, 6, 0, 0);
    @(posedge clk); #1;
    set_cmd(1, 0, 4, 4, 0, 0, 0, 0);
    @(posedge clk); #1;
    rs.cmd_valid = 1'b0;
    @(posedge clk); #1;
    rs.le_we = 1'b1; rs.le_x = 3'd3; rs.le_y = 3'd1;
    @(negedge clk);
    total++;
    if (rs.fb_we !== 1'b1 || rs.fb_x !== 3'd3 || rs.fb_y !== 3'd1) begin
      bad++; $display("FAIL lwait_forward: fb_we=%0d (%0d,%0d) want 1 (3,1)", rs.fb_we, rs.fb_x, rs.fb_y);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (outvec() !== 26'd0) begin
      bad++; $display("FAIL reset_mid_line: outputs=%h want 0", outvec());
    end
    rs.le_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap.delete();
    repeat (10) @(negedge clk);
    total++;
    if (cap.size() != 0 || rs.busy !== 1'b0) begin
      bad++; $display("FAIL reset_flush: writes=%0d busy=%0d want 0/0", cap.size(), rs.busy);
    end
    $display("reset mid-line: writes after reset=%0d busy=%0d", cap.size(), rs.busy);
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_rect();
    test_clear();
    test_scan();
    test_back_to_back();
    test_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
